// File: rtl/priv_pkg.sv
// Shared types for the ring-0/ring-3 privilege guard: fault causes, FSM states, enforcement modes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package priv_pkg;

  // Fault cause codes as seen on fault_cause; NONE means no unhandled fault.
  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_JUMP   = 3'd1,
    CAUSE_MEM    = 3'd2,
    CAUSE_WREG   = 3'd3,
    CAUSE_RREG_A = 3'd4,
    CAUSE_RREG_B = 3'd5
  } cause_e;

  // Enforcement FSM: FAULT is the single registration cycle before HALTED/TRAP.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FAULT  = 2'd1,
    ST_HALTED = 2'd2,
    ST_TRAP   = 2'd3
  } state_e;

  // Enforcement modes selected by the ENFORCE parameter.
  localparam int MODE_REPORT = 0;
  localparam int MODE_HALT   = 1;
  localparam int MODE_TRAP   = 2;

  // Width helper for the shared fault address bus.
  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/priv_checker.sv
// Combinational violation detection for unprivileged code, with fixed-priority cause selection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluates every cycle.
module priv_checker
  import priv_pkg::*;
#(
  parameter int PC_W           = 16,
  parameter int ADDR_W         = 16,
  parameter int SEL_W          = 5,
  parameter int RING0_PC_LAST  = 65535,
  parameter int RING0_ENTRY    = 0,
  parameter int RING0_MEM_LAST = 0,
  parameter int RING0_REG_LAST = 0
) (
  input  logic                           privileged,
  input  logic                           jump,
  input  logic [PC_W-1:0]                jump_target,
  input  logic                           mem_en,
  input  logic [ADDR_W-1:0]              mem_addr,
  input  logic                           rd_a_en,
  input  logic [SEL_W-1:0]               rd_a_sel,
  input  logic                           rd_b_en,
  input  logic [SEL_W-1:0]               rd_b_sel,
  input  logic                           wr_en,
  input  logic [SEL_W-1:0]               wr_sel,
  output logic                           any_violation,
  output cause_e                         cause,
  output logic [max_w(PC_W, ADDR_W)-1:0] addr
);

  localparam int AW = max_w(PC_W, ADDR_W);
  localparam logic [PC_W-1:0] PC_ENTRY = PC_W'(RING0_ENTRY);

  logic v_jump, v_mem, v_wreg, v_rreg_a, v_rreg_b;

  // Individual checks; bounds compared at 32 bits so an all-ones bound never degenerates.
  always_comb begin
    v_jump   = !privileged && jump && (32'(jump_target) <= 32'(RING0_PC_LAST))
               && (jump_target != PC_ENTRY);
    v_mem    = !privileged && mem_en  && (32'(mem_addr) <= 32'(RING0_MEM_LAST));
    v_wreg   = !privileged && wr_en   && (32'(wr_sel)   <= 32'(RING0_REG_LAST));
    v_rreg_a = !privileged && rd_a_en && (32'(rd_a_sel) <= 32'(RING0_REG_LAST));
    v_rreg_b = !privileged && rd_b_en && (32'(rd_b_sel) <= 32'(RING0_REG_LAST));
  end

  // Priority encode: JUMP > MEM > WREG > RREG_A > RREG_B, reporting the offending value.
  always_comb begin
    any_violation = v_jump | v_mem | v_wreg | v_rreg_a | v_rreg_b;
    cause         = CAUSE_NONE;
    addr          = '0;
    if (v_jump) begin
      cause = CAUSE_JUMP;
      addr  = AW'(jump_target);
    end else if (v_mem) begin
      cause = CAUSE_MEM;
      addr  = AW'(mem_addr);
    end else if (v_wreg) begin
      cause = CAUSE_WREG;
      addr  = AW'(wr_sel);
    end else if (v_rreg_a) begin
      cause = CAUSE_RREG_A;
      addr  = AW'(rd_a_sel);
    end else if (v_rreg_b) begin
      cause = CAUSE_RREG_B;
      addr  = AW'(rd_b_sel);
    end
  end

endmodule

// File: rtl/privilege_guard.sv
// Ring-0/ring-3 protection: offsets, fault latch, saturating counter and report/halt/trap enforcement.
// Latency: fault 1 cycle after the violating cycle; halt/trap_valid 2 cycles after it.
// Backpressure: trap_valid holds until trap_ready; HALTED holds until fault_clear.
module privilege_guard
  import priv_pkg::*;
#(
  parameter int PC_W           = 16,
  parameter int ADDR_W         = 16,
  parameter int SEL_W          = 5,
  parameter int RING0_PC_LAST  = 65535,
  parameter int RING0_ENTRY    = 0,
  parameter int RING0_MEM_LAST = 0,
  parameter int RING0_REG_LAST = 0,
  parameter int USER_OFFSET    = 65536,
  parameter int ENFORCE        = 1,
  parameter int CNT_W          = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [PC_W-1:0]                pc,
  input  logic                           jump,
  input  logic [PC_W-1:0]                jump_target,
  input  logic                           syscall,
  input  logic                           mem_en,
  input  logic [ADDR_W-1:0]              mem_addr,
  input  logic [SEL_W-1:0]               rd_a_sel,
  input  logic [SEL_W-1:0]               rd_b_sel,
  input  logic                           rd_a_en,
  input  logic                           rd_b_en,
  input  logic                           wr_en,
  input  logic [SEL_W-1:0]               wr_sel,
  input  logic                           fault_clear,
  input  logic                           trap_ready,
  output logic                           privileged,
  output logic [PC_W:0]                  prog_offset,
  output logic [ADDR_W:0]                data_offset,
  output logic                           fault,
  output logic [2:0]                     fault_cause,
  output logic [max_w(PC_W, ADDR_W)-1:0] fault_addr,
  output logic                           halt,
  output logic                           trap_valid,
  output logic [PC_W-1:0]                trap_pc,
  output logic [CNT_W-1:0]               fault_count
);

  localparam int AW = max_w(PC_W, ADDR_W);
  localparam logic [PC_W:0]   PROG_USER = (PC_W+1)'(USER_OFFSET);
  localparam logic [ADDR_W:0] DATA_USER = (ADDR_W+1)'(USER_OFFSET);

  state_e           state_q, state_n;
  logic             fault_q, fault_n;
  cause_e           cause_q, cause_n;
  logic [AW-1:0]    addr_q, addr_n;
  logic [CNT_W-1:0] cnt_q;
  logic             any_violation;
  cause_e           viol_cause;
  logic [AW-1:0]    viol_addr;
  logic             run_like;

  // Ring classification and memory relocation; a syscall runs its fetches from ring-0 program space.
  always_comb begin
    privileged  = (32'(pc) <= 32'(RING0_PC_LAST));
    prog_offset = (privileged || syscall) ? '0 : PROG_USER;
    data_offset = privileged ? '0 : DATA_USER;
  end

  priv_checker #(
    .PC_W          (PC_W),
    .ADDR_W        (ADDR_W),
    .SEL_W         (SEL_W),
    .RING0_PC_LAST (RING0_PC_LAST),
    .RING0_ENTRY   (RING0_ENTRY),
    .RING0_MEM_LAST(RING0_MEM_LAST),
    .RING0_REG_LAST(RING0_REG_LAST)
  ) u_checker (
    .privileged   (privileged),
    .jump         (jump),
    .jump_target  (jump_target),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .rd_a_en      (rd_a_en),
    .rd_a_sel     (rd_a_sel),
    .rd_b_en      (rd_b_en),
    .rd_b_sel     (rd_b_sel),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .any_violation(any_violation),
    .cause        (viol_cause),
    .addr         (viol_addr)
  );

  // Next state and fault record; HALTED with fault_clear behaves like RUN so a same-cycle violation re-latches.
  always_comb begin
    state_n  = state_q;
    fault_n  = fault_q;
    cause_n  = cause_q;
    addr_n   = addr_q;
    run_like = 1'b0;
    case (state_q)
      ST_RUN:    run_like = 1'b1;
      ST_HALTED: run_like = fault_clear;
      ST_FAULT:  state_n  = (ENFORCE == MODE_TRAP) ? ST_TRAP : ST_HALTED;
      ST_TRAP:   if (trap_ready) state_n = ST_RUN;
      default:   state_n  = ST_RUN;
    endcase
    if (run_like) begin
      state_n = ST_RUN;
      if (fault_clear) begin
        fault_n = 1'b0;
        cause_n = CAUSE_NONE;
        addr_n  = '0;
      end
      if (any_violation) begin
        // Report mode keeps the first unhandled cause; halt/trap record every fault they act on.
        if ((ENFORCE != MODE_REPORT) || !fault_n) begin
          cause_n = viol_cause;
          addr_n  = viol_addr;
        end
        fault_n = 1'b1;
        if (ENFORCE != MODE_REPORT) state_n = ST_FAULT;
      end
    end
  end

  // State and fault record registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RUN;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
      addr_q  <= '0;
    end else begin
      state_q <= state_n;
      fault_q <= fault_n;
      cause_q <= cause_n;
      addr_q  <= addr_n;
    end
  end

  // Saturating count of faulting cycles, counted in every state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (any_violation && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign fault_addr  = addr_q;
  assign halt        = (state_q == ST_HALTED);
  assign trap_valid  = (state_q == ST_TRAP);
  assign trap_pc     = PC_W'(RING0_ENTRY);
  assign fault_count = cnt_q;

endmodule
